// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl
//   Store-path controller for a multi-cycle MIPS datapath. Accepts register B
//   data plus a store size and writes it to word-organised memory. SW is
//   written straight through; SH/SB read the containing word, merge the new
//   lane(s) in, and write the word back. Misaligned or illegal requests are
//   reported with err on the done pulse and never touch memory.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request pulse, sampled only in IDLE
//   size       in   00=SW, 01=SH, 10=SB, 11=illegal
//   addr       in   byte address of the store
//   wdata      in   store data (low 16/8 bits used for SH/SB)
//   mem_rdata  in   memory read data, valid MEM_LAT cycles after mem_rd
//   mem_addr   out  word-aligned address while busy, 0 in IDLE
//   mem_wdata  out  word to write, driven only during the write cycle
//   mem_rd     out  one-cycle read strobe
//   mem_wr     out  one-cycle write strobe
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   err        out  qualified by done; request rejected, nothing written
module store_rmw_ctrl #(
  parameter int MEM_LAT = 1  // read latency, legal 1..4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  // Counter reloads to MEM_LAT-1 so WAIT lasts exactly MEM_LAT cycles.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_q, addr_next;
  logic [1:0]  size_q, size_next;
  logic [31:0] wbuf, wbuf_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        err_q, err_next;

  logic        cap_err;
  logic [31:0] merged;

  // Alignment / legality decided from the live inputs at capture time.
  assign cap_err = (size == 2'b11) ||
                   ((size == SZ_W) && (addr[1:0] != 2'b00)) ||
                   ((size == SZ_H) && addr[0]);

  // Per-lane merge: a lane takes store data when it is addressed by the
  // captured size/offset, otherwise it keeps the word read from memory.
  // For SH the upper half reuses wbuf[15:0], so lane n draws from
  // wbuf byte (n mod 2); SB always draws from wbuf[7:0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       sel;
      logic [7:0] src;
      assign sel = ((size_q == SZ_B) && (addr_q[1:0] == LANE)) ||
                   ((size_q == SZ_H) && (addr_q[1] == LANE[1]));
      assign src = (size_q == SZ_B) ? wbuf[7:0] : wbuf[8*(gi%2) +: 8];
      assign merged[8*gi +: 8] = sel ? src : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wbuf      <= '0;
      cnt_reg   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_q    <= addr_next;
      size_q    <= size_next;
      wbuf      <= wbuf_next;
      cnt_reg   <= cnt_next;
      err_q     <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_q;
    size_next  = size_q;
    wbuf_next  = wbuf;
    cnt_next   = cnt_reg;
    err_next   = err_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = 1'b1;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wdata  = '0;

    case (state_reg)
      IDLE: begin
        busy     = 1'b0;
        mem_addr = '0;
        if (start) begin
          addr_next = addr;
          size_next = size;
          wbuf_next = wdata;
          err_next  = cap_err;
          if (cap_err)
            state_next = DONE;
          else if (size == SZ_W)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ: begin
        mem_rd     = 1'b1;
        cnt_next   = CNT_INIT;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 2'd0) begin
          wbuf_next  = merged;
          state_next = WRITE;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      WRITE: begin
        mem_wr     = 1'b1;
        mem_wdata  = wbuf;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        err        = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl. Two instances (MEM_LAT=1 and 3) share
// the request inputs; each has its own memory model that presents the word
// only in the cycle its read data is due, and garbage otherwise.
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_word = '0;

  logic [31:0] mem_rdata_a, mem_addr_a, mem_wdata_a;
  logic        mem_rd_a, mem_wr_a, busy_a, done_a, err_a;
  logic [31:0] mem_rdata_b, mem_addr_b, mem_wdata_b;
  logic        mem_rd_b, mem_wr_b, busy_b, done_b, err_b;

  logic [3:0] pipe_a = '0;
  logic [3:0] pipe_b = '0;

  int checks = 0;
  int errors = 0;

  int          n_rd[2], n_wr[2], n_done[2], n_both[2];
  int          rd_cyc[2], wr_cyc[2], done_cyc[2];
  logic [31:0] wr_addr[2], wr_data[2];
  logic        done_err[2], busy_last[2];

  always #5 clk = ~clk;

  store_rmw_ctrl #(.MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .wdata(wdata), .mem_rdata(mem_rdata_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  store_rmw_ctrl #(.MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .wdata(wdata), .mem_rdata(mem_rdata_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Memory: read data is valid exactly MEM_LAT cycles after the mem_rd cycle.
  always @(posedge clk) begin
    pipe_a <= {pipe_a[2:0], mem_rd_a};
    pipe_b <= {pipe_b[2:0], mem_rd_b};
  end
  assign mem_rdata_a = pipe_a[0] ? mem_word : 32'hA5A5A5A5;
  assign mem_rdata_b = pipe_b[2] ? mem_word : 32'hA5A5A5A5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rec(input int i, input int k, input logic rd, input logic wr,
                     input logic bz, input logic dn, input logic er,
                     input logic [31:0] ad, input logic [31:0] wd);
    if (rd) begin n_rd[i]++; rd_cyc[i] = k; end
    if (wr) begin n_wr[i]++; wr_cyc[i] = k; wr_addr[i] = ad; wr_data[i] = wd; end
    if (rd && wr) n_both[i]++;
    if (dn) begin n_done[i]++; done_cyc[i] = k; done_err[i] = er; end
    busy_last[i] = bz;
  endtask

  // Issue one request, then observe ncyc cycles (cycle 1 = first after the
  // capture edge). start is re-raised in cycles 1..spam; reset is raised in
  // cycle abort_at (0 = never). Inputs are scrambled after capture.
  task automatic run_op(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] word, input int ncyc, input int spam,
                        input int abort_at);
    @(negedge clk);
    size = sz; addr = a; wdata = d; mem_word = word; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_rd[i] = 0; n_wr[i] = 0; n_done[i] = 0; n_both[i] = 0;
      rd_cyc[i] = -1; wr_cyc[i] = -1; done_cyc[i] = -1;
      wr_addr[i] = '0; wr_data[i] = '0; done_err[i] = 1'b0; busy_last[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0; addr = ~a; wdata = ~d; size = 2'b11;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      rec(0, k, mem_rd_a, mem_wr_a, busy_a, done_a, err_a, mem_addr_a, mem_wdata_a);
      rec(1, k, mem_rd_b, mem_wr_b, busy_b, done_b, err_b, mem_addr_b, mem_wdata_b);
      start = (k <= spam);
      reset = (k == abort_at);
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  // kind: 0 = SW, 1 = SH/SB read-modify-write, 2 = rejected request
  task automatic verify(input string tag, input int kind,
                        input logic [31:0] exp_addr, input logic [31:0] exp_data);
    for (int i = 0; i < 2; i++) begin
      int    lat;
      string t;
      lat = (i == 0) ? 1 : 3;
      t = {tag, (i == 0) ? "/L1" : "/L3"};
      check_eq({t, ".both"}, n_both[i], 0);
      check_eq({t, ".ndone"}, n_done[i], 1);
      if (kind == 2) begin
        check_eq({t, ".nrd"}, n_rd[i], 0);
        check_eq({t, ".nwr"}, n_wr[i], 0);
        check_eq({t, ".done_cyc"}, done_cyc[i], 1);
        check_eq({t, ".err"}, {31'b0, done_err[i]}, 1);
      end else begin
        check_eq({t, ".nrd"}, n_rd[i], (kind == 1) ? 1 : 0);
        check_eq({t, ".nwr"}, n_wr[i], 1);
        check_eq({t, ".wr_addr"}, wr_addr[i], exp_addr);
        check_eq({t, ".wr_data"}, wr_data[i], exp_data);
        check_eq({t, ".err"}, {31'b0, done_err[i]}, 0);
        if (kind == 1) begin
          check_eq({t, ".rd_cyc"}, rd_cyc[i], 1);
          check_eq({t, ".wr_cyc"}, wr_cyc[i], 2 + lat);
          check_eq({t, ".done_cyc"}, done_cyc[i], 3 + lat);
        end else begin
          check_eq({t, ".wr_cyc"}, wr_cyc[i], 1);
          check_eq({t, ".done_cyc"}, done_cyc[i], 2);
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".ctl_a"}, {27'b0, mem_rd_a, mem_wr_a, busy_a, done_a, err_a}, 0);
    check_eq({tag, ".bus_a"}, mem_addr_a | mem_wdata_a, 0);
    check_eq({tag, ".ctl_b"}, {27'b0, mem_rd_b, mem_wr_b, busy_b, done_b, err_b}, 0);
    check_eq({tag, ".bus_b"}, mem_addr_b | mem_wdata_b, 0);
  endtask

  initial begin
    // Reset held two cycles with start high
    reset = 1'b1; start = 1'b1; size = 2'b00; addr = 32'h100; wdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("rst");
      $display("reset cycle %0d checked", c);
    end
    reset = 1'b0; start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_idle("post_rst");
    end
    $display("post-reset idle checked");

    run_op(2'b00, 32'h100, 32'hDEADBEEF, 32'h11223344, 4, 0, 0);
    verify("sw", 0, 32'h100, 32'hDEADBEEF);
    $display("SW 0x100 <= DEADBEEF");

    run_op(2'b10, 32'h202, 32'h000000AB, 32'h11223344, 8, 0, 0);
    verify("sb2", 1, 32'h200, 32'h11AB3344);
    $display("SB 0x202 <= AB");

    run_op(2'b01, 32'h302, 32'h0000CAFE, 32'h11223344, 8, 0, 0);
    verify("sh_hi", 1, 32'h300, 32'hCAFE3344);
    $display("SH 0x302 <= CAFE");

    run_op(2'b10, 32'h401, 32'h9999995A, 32'h11223344, 8, 0, 0);
    verify("sb1", 1, 32'h400, 32'h11225A44);
    $display("SB 0x401 <= 5A");

    run_op(2'b01, 32'h500, 32'h1234BEEF, 32'h11223344, 8, 0, 0);
    verify("sh_lo", 1, 32'h500, 32'h1122BEEF);
    $display("SH 0x500 <= BEEF");

    run_op(2'b10, 32'h603, 32'h00000077, 32'h11223344, 8, 0, 0);
    verify("sb3", 1, 32'h600, 32'h77223344);
    $display("SB 0x603 <= 77");

    run_op(2'b00, 32'h101, 32'h12345678, 32'h11223344, 4, 0, 0);
    verify("err_sw", 2, 32'h0, 32'h0);
    $display("SW 0x101 rejected");

    run_op(2'b01, 32'h103, 32'h12345678, 32'h11223344, 4, 0, 0);
    verify("err_sh", 2, 32'h0, 32'h0);
    $display("SH 0x103 rejected");

    run_op(2'b11, 32'h100, 32'h12345678, 32'h11223344, 4, 0, 0);
    verify("err_sz", 2, 32'h0, 32'h0);
    $display("size=11 rejected");

    // Reset during WAIT of an SB: no write, no done, back in IDLE
    run_op(2'b10, 32'h202, 32'h000000AB, 32'h11223344, 10, 0, 2);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("abort%0d.nwr", i), n_wr[i], 0);
      check_eq($sformatf("abort%0d.ndone", i), n_done[i], 0);
      check_eq($sformatf("abort%0d.busy", i), {31'b0, busy_last[i]}, 0);
    end
    $display("SB aborted by reset in WAIT");

    // start held through the busy and done cycles is ignored
    run_op(2'b00, 32'h700, 32'h01234567, 32'h11223344, 6, 2, 0);
    verify("spam", 0, 32'h700, 32'h01234567);
    $display("SW 0x700 with start held while busy");

    // Second SW starts in the cycle right after the first done
    run_op(2'b00, 32'h800, 32'hAAAA5555, 32'h11223344, 2, 0, 0);
    verify("b2b1", 0, 32'h800, 32'hAAAA5555);
    $display("SW 0x800 (first of pair)");
    run_op(2'b00, 32'h804, 32'h5555AAAA, 32'h11223344, 4, 0, 0);
    verify("b2b2", 0, 32'h804, 32'h5555AAAA);
    $display("SW 0x804 (back-to-back)");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
- Store-path counterpart of the load/MDR path in the multi-cycle MIPS datapath.
- Takes register B data plus a store size (SW/SH/SB) and writes it to word-organised memory.
- SW writes directly.
- SH/SB do a read-modify-write: read the word, merge the B lane into it, write it back.
- Sits between the main control FSM (start/done handshake) and the memory port.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_rd to valid mem_rdata (legal 1..4).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- size  input  2  00=word (SW), 01=half (SH), 10=byte (SB), 11=illegal
- addr  input  32  byte address of the store
- wdata  input  32  store data from register B; low 16/8 bits used for SH/SB
- mem_rdata  input  32  memory read data
- mem_addr  output  32  word-aligned address {addr_q[31:2],2'b00}
- mem_wdata  output  32  word to write
- mem_rd  output  1  one-cycle read strobe
- mem_wr  output  1  one-cycle write strobe
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; 1 = misaligned or illegal size, nothing written

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all outputs 0, internal addr_q/size_q/wbuf/counter cleared.
- Reset mid-operation aborts in the same edge: no further mem_rd/mem_wr, done not pulsed.
- Capture: on a clock edge in IDLE with start=1, latch addr, size and wdata into addr_q, size_q, wbuf.
  - Later changes on addr, size or wdata have no effect.
  - start outside IDLE is ignored; it is not queued.
- Error check, evaluated at capture:
  - size=11 is an error.
  - SW with addr[1:0]!=0 is an error.
  - SH with addr[0]=1 is an error.
  - SB is always aligned.
  - On error: next state is DONE with err=1; mem_rd and mem_wr stay 0 throughout.
- States: IDLE, READ, WAIT, WRITE, DONE.
  - IDLE -> WRITE: start, SW, aligned.
  - IDLE -> READ: start, SH/SB, aligned.
  - IDLE -> DONE: start with error.
  - READ: mem_rd=1 for exactly one cycle -> WAIT.
  - WAIT: stays MEM_LAT cycles, counter counts MEM_LAT-1 down to 0.
    - In the cycle the counter is 0, mem_rdata is valid.
    - At that edge, wbuf <= merged word -> WRITE.
  - WRITE: mem_wr=1 for exactly one cycle, mem_wdata=wbuf -> DONE.
  - DONE: done=1 for one cycle, err as decided -> IDLE.
- Merge, little-endian lanes; lane n = bits [8n+7:8n].
  - SB: lane addr_q[1:0] replaced by wdata_q[7:0]; other lanes taken from mem_rdata.
  - SH: addr_q[1]=0 replaces bits [15:0] with wdata_q[15:0]; addr_q[1]=1 replaces bits [31:16].
  - SW: wbuf unchanged.
- Output timing:
  - mem_addr is driven from addr_q while busy, 0 in IDLE.
  - mem_wdata is driven from wbuf only in WRITE, otherwise 0.
- Latency, counting the start-capture edge as cycle 0:
  - SW: mem_wr in cycle 1, done in cycle 2.
  - SH/SB: mem_rd in cycle 1, mem_wr in cycle 2+MEM_LAT, done in cycle 3+MEM_LAT.
  - Error: done+err in cycle 1.
- Back-to-back: start may be asserted in the cycle after done, since the block is then in IDLE. A start coincident with done is ignored.
- mem_rd and mem_wr are never high in the same cycle.

Test Plan:
- Reset/idle: assert reset 2 cycles with start=1 -> all outputs 0 and busy=0; after release with start=0, outputs remain 0.
- SW: addr=0x100, wdata=0xDEADBEEF -> cycle1: mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; cycle2: done=1, err=0; mem_rd never asserted.
- SB lane 2, MEM_LAT=1: addr=0x202, wdata=0x000000AB, mem_rdata=0x11223344 -> mem_rd in cycle1; in cycle3 mem_wr=1, mem_addr=0x200, mem_wdata=0x11AB3344; done in cycle4.
- SH upper, MEM_LAT=3: addr=0x302, wdata=0x0000CAFE, mem_rdata=0x11223344 -> mem_wr in cycle5 with mem_wdata=0xCAFE3344; done in cycle6.
- Errors: SW addr=0x101, SH addr=0x103, size=11 -> each gives done=1, err=1 in cycle1; mem_rd=mem_wr=0 throughout.
- Abort and ignore:
  - reset asserted in WAIT during an SB -> no mem_wr, no done, block in IDLE.
  - start pulses while busy -> ignored, exactly one write per accepted start.
  - a new SW started the cycle after done completes normally.
